// File: rtl/vga_pkg.sv
// Shared VGA types: pixel type, standard mode timings and sync polarity.
package vga_pkg;

  localparam int unsigned RgbBitsDefault = 4;

  typedef logic [2:0][RgbBitsDefault-1:0] rgb_t;

  typedef enum logic {
    PolNeg = 1'b0,
    PolPos = 1'b1
  } vga_pol_e;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_front;
    logic [15:0] h_sync;
    logic [15:0] h_back;
    logic [15:0] v_active;
    logic [15:0] v_front;
    logic [15:0] v_sync;
    logic [15:0] v_back;
    vga_pol_e    hsync_pol;
    vga_pol_e    vsync_pol;
  } vga_timing_t;

  localparam vga_timing_t Mode640x480At60 = '{
    h_active: 16'd640, h_front: 16'd16, h_sync: 16'd96, h_back: 16'd48,
    v_active: 16'd480, v_front: 16'd10, v_sync: 16'd2, v_back: 16'd33,
    hsync_pol: PolNeg, vsync_pol: PolNeg
  };

  localparam vga_timing_t Mode800x600At60 = '{
    h_active: 16'd800, h_front: 16'd40, h_sync: 16'd128, h_back: 16'd88,
    v_active: 16'd600, v_front: 16'd1, v_sync: 16'd4, v_back: 16'd23,
    hsync_pol: PolPos, vsync_pol: PolPos
  };

  // Pin level for a sync signal given whether the pulse is active.
  function automatic logic sync_level(input logic active, input vga_pol_e pol);
    return ~(active ^ pol);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping counter 0..max_p with combinational terminal-count output.
module vga_axis_counter #(
  parameter int unsigned max_p   = 7,
  parameter int unsigned width_p = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [width_p-1:0] count,
  output logic               tc
);

  assign tc = (count == width_p'(max_p));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_stream.sv
// Parametrised VGA timing generator with a never-stalling valid/ready pixel sink.
module vga_timing_stream
  import vga_pkg::*;
#(
  parameter int unsigned pixel_bits_p = 4,
  parameter int unsigned h_active_p   = 640,
  parameter int unsigned h_front_p    = 16,
  parameter int unsigned h_sync_p     = 96,
  parameter int unsigned h_back_p     = 48,
  parameter int unsigned v_active_p   = 480,
  parameter int unsigned v_front_p    = 10,
  parameter int unsigned v_sync_p     = 2,
  parameter int unsigned v_back_p     = 33,
  parameter bit          hsync_pol_p  = 1'b0,
  parameter bit          vsync_pol_p  = 1'b0,
  parameter int unsigned fill_color_p = 0,
  localparam int unsigned HTotal = h_active_p + h_front_p + h_sync_p + h_back_p,
  localparam int unsigned VTotal = v_active_p + v_front_p + v_sync_p + v_back_p,
  localparam int unsigned XW     = $clog2(HTotal),
  localparam int unsigned YW     = $clog2(VTotal)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [2:0][pixel_bits_p-1:0] data_i,
  output logic [XW-1:0]                x_o,
  output logic [YW-1:0]                y_o,
  output logic                         hsync_o,
  output logic                         vsync_o,
  output logic                         disp_en_o,
  output logic [2:0][pixel_bits_p-1:0] data_o,
  output logic                         frame_start_o,
  output logic                         underflow_o,
  input  logic                         clear_underflow_i
);

  localparam int unsigned RgbW    = 3 * pixel_bits_p;
  localparam int unsigned HsStart = h_active_p + h_front_p;
  localparam int unsigned HsEnd   = HsStart + h_sync_p;
  localparam int unsigned VsStart = v_active_p + v_front_p;
  localparam int unsigned VsEnd   = VsStart + v_sync_p;
  localparam vga_pol_e    HsPol   = vga_pol_e'(hsync_pol_p);
  localparam vga_pol_e    VsPol   = vga_pol_e'(vsync_pol_p);
  localparam logic [2:0][pixel_bits_p-1:0] FillColor = RgbW'(fill_color_p);

  if (pixel_bits_p < 1 || h_active_p < 1 || h_sync_p < 1 || v_active_p < 1 || v_sync_p < 1)
  begin : g_bad_param
    $error("vga_timing_stream: widths, active and sync sizes must be at least 1");
  end
  if ((fill_color_p >> RgbW) != 0) begin : g_bad_fill
    $error("vga_timing_stream: fill_color_p does not fit 3*pixel_bits_p bits");
  end

  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic          sx_tc;
  logic          unused_sy_tc;

  vga_axis_counter #(
    .max_p  (HTotal - 1),
    .width_p(XW)
  ) u_sx (
    .clk  (clk_i),
    .reset(reset_i),
    .en   (1'b1),
    .count(sx),
    .tc   (sx_tc)
  );

  vga_axis_counter #(
    .max_p  (VTotal - 1),
    .width_p(YW)
  ) u_sy (
    .clk  (clk_i),
    .reset(reset_i),
    .en   (sx_tc),
    .count(sy),
    .tc   (unused_sy_tc)
  );

  logic de_raw, hs_raw, vs_raw, transfer, uf_set, underflow_next;
  logic [2:0][pixel_bits_p-1:0] data_next;

  assign de_raw = (int'(sx) < h_active_p) && (int'(sy) < v_active_p);
  assign hs_raw = (int'(sx) >= HsStart) && (int'(sx) < HsEnd);
  assign vs_raw = (int'(sy) >= VsStart) && (int'(sy) < VsEnd);

  assign ready_o  = de_raw;
  assign x_o      = sx;
  assign y_o      = sy;
  assign transfer = ready_o && valid_i;
  assign uf_set   = de_raw && !valid_i;

  always_comb begin
    data_next = '0;
    if (transfer) begin
      data_next = data_i;
    end else if (de_raw) begin
      data_next = FillColor;
    end
    // A fresh underflow outranks a simultaneous clear.
    underflow_next = uf_set | (underflow_o & ~clear_underflow_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      disp_en_o     <= 1'b0;
      hsync_o       <= sync_level(1'b0, HsPol);
      vsync_o       <= sync_level(1'b0, VsPol);
      data_o        <= '0;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      disp_en_o     <= de_raw;
      hsync_o       <= sync_level(hs_raw, HsPol);
      vsync_o       <= sync_level(vs_raw, VsPol);
      data_o        <= data_next;
      frame_start_o <= (sx == '0) && (sy == '0);
      underflow_o   <= underflow_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_stream.sv
// Two small-mode instances (negative and positive sync) checked against an arithmetic model.
module tb_vga_timing_stream;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int fill;
  } cfg_t;

  typedef struct {
    bit de, hs, vs, fs, uf;
    logic [11:0] data;
  } exp_t;

  localparam cfg_t CA = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 2, vf: 1, vs: 1, vb: 1,
                          hp: 1'b0, vp: 1'b0, fill: 'hA5C};
  localparam cfg_t CB = '{ha: 20, hf: 3, hs: 5, hb: 4, va: 6, vf: 2, vs: 2, vb: 3,
                          hp: 1'b1, vp: 1'b1, fill: 'h1C5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic va, ra, clra, hsa, vsa, dea, fsa, ufa;
  logic [2:0][3:0] da, oa;
  logic [2:0] xa, ya;
  logic vb, rb, clrb, hsb, vsb, deb, fsb, ufb;
  logic [2:0][2:0] db, ob;
  logic [4:0] xb;
  logic [3:0] yb;

  vga_timing_stream #(
    .pixel_bits_p(4), .h_active_p(4), .h_front_p(1), .h_sync_p(2), .h_back_p(1),
    .v_active_p(2), .v_front_p(1), .v_sync_p(1), .v_back_p(1),
    .hsync_pol_p(1'b0), .vsync_pol_p(1'b0), .fill_color_p('hA5C)
  ) dut_a (
    .clk_i(clk), .reset_i(reset), .valid_i(va), .ready_o(ra), .data_i(da), .x_o(xa), .y_o(ya),
    .hsync_o(hsa), .vsync_o(vsa), .disp_en_o(dea), .data_o(oa), .frame_start_o(fsa),
    .underflow_o(ufa), .clear_underflow_i(clra)
  );

  vga_timing_stream #(
    .pixel_bits_p(3), .h_active_p(20), .h_front_p(3), .h_sync_p(5), .h_back_p(4),
    .v_active_p(6), .v_front_p(2), .v_sync_p(2), .v_back_p(3),
    .hsync_pol_p(1'b1), .vsync_pol_p(1'b1), .fill_color_p('h1C5)
  ) dut_b (
    .clk_i(clk), .reset_i(reset), .valid_i(vb), .ready_o(rb), .data_i(db), .x_o(xb), .y_o(yb),
    .hsync_o(hsb), .vsync_o(vsb), .disp_en_o(deb), .data_o(ob), .frame_start_o(fsb),
    .underflow_o(ufb), .clear_underflow_i(clrb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ta = 0, tb = 0;
  exp_t ea, eb;

  function automatic int htot(cfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
  function automatic int vtot(cfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction
  function automatic int pos_x(cfg_t c, int t); return t % htot(c); endfunction
  function automatic int pos_y(cfg_t c, int t); return (t / htot(c)) % vtot(c); endfunction

  function automatic bit active(cfg_t c, int t);
    return pos_x(c, t) < c.ha && pos_y(c, t) < c.va;
  endfunction

  // Pins one cycle after the counters sit at position t with the given inputs.
  function automatic exp_t predict(cfg_t c, int t, bit rst, bit v, logic [11:0] d,
                                   bit uf_prev, bit clr);
    exp_t e;
    int x, y;
    bit h_act, v_act;
    x = pos_x(c, t);
    y = pos_y(c, t);
    if (rst) begin
      e = '{de: 1'b0, hs: !c.hp, vs: !c.vp, fs: 1'b0, uf: 1'b0, data: 12'h0};
      return e;
    end
    h_act  = x >= c.ha + c.hf && x < c.ha + c.hf + c.hs;
    v_act  = y >= c.va + c.vf && y < c.va + c.vf + c.vs;
    e.de   = active(c, t);
    e.hs   = c.hp ? h_act : !h_act;
    e.vs   = c.vp ? v_act : !v_act;
    e.fs   = (x == 0 && y == 0);
    e.data = !e.de ? 12'h0 : (v ? d : 12'(c.fill));
    e.uf   = (e.de && !v) || (uf_prev && !clr);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // vmode: 0 = mostly valid at random, 1 = always valid, 2 = never valid.
  task automatic cycle(input bit rst, input int vmode, input bit clr);
    bit v_a, v_b;
    logic [11:0] d_a, d_b;
    v_a = (vmode == 1) ? 1'b1 : (vmode == 2) ? 1'b0 : ($urandom_range(0, 9) != 0);
    v_b = (vmode == 1) ? 1'b1 : (vmode == 2) ? 1'b0 : ($urandom_range(0, 9) != 0);
    d_a = 12'($urandom);
    d_b = 12'($urandom) & 12'h1FF;
    reset = rst;
    va = v_a; da = d_a; clra = clr;
    vb = v_b; db = 9'(d_b); clrb = clr;
    ea = predict(CA, ta, rst, v_a, d_a, ea.uf, clr);
    eb = predict(CB, tb, rst, v_b, d_b, eb.uf, clr);
    ta = rst ? 0 : ta + 1;
    tb = rst ? 0 : tb + 1;
    @(posedge clk);
    #1;
    chk("a.disp_en", 32'(dea), 32'(ea.de));
    chk("a.hsync", 32'(hsa), 32'(ea.hs));
    chk("a.vsync", 32'(vsa), 32'(ea.vs));
    chk("a.data", 32'(oa), 32'(ea.data));
    chk("a.frame_start", 32'(fsa), 32'(ea.fs));
    chk("a.underflow", 32'(ufa), 32'(ea.uf));
    chk("a.x", 32'(xa), 32'(pos_x(CA, ta)));
    chk("a.y", 32'(ya), 32'(pos_y(CA, ta)));
    chk("a.ready", 32'(ra), 32'(active(CA, ta)));
    chk("b.disp_en", 32'(deb), 32'(eb.de));
    chk("b.hsync", 32'(hsb), 32'(eb.hs));
    chk("b.vsync", 32'(vsb), 32'(eb.vs));
    chk("b.data", 32'(ob), 32'(eb.data));
    chk("b.frame_start", 32'(fsb), 32'(eb.fs));
    chk("b.underflow", 32'(ufb), 32'(eb.uf));
    chk("b.x", 32'(xb), 32'(pos_x(CB, tb)));
    chk("b.y", 32'(yb), 32'(pos_y(CB, tb)));
    chk("b.ready", 32'(rb), 32'(active(CB, tb)));
  endtask

  initial begin
    ea = '{de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0, uf: 1'b0, data: 12'h0};
    eb = ea;
    reset = 1'b1;
    va = 1'b0; da = '0; clra = 1'b0;
    vb = 1'b0; db = '0; clrb = 1'b0;

    // Reset, then two full frames of the larger mode with random valid and clears.
    repeat (3) cycle(1'b1, 0, 1'b0);
    repeat (840) cycle(1'b0, 0, ($urandom_range(0, 7) == 0));

    // Reset mid-line in the active region.
    for (int i = 0; i < 64 && pos_x(CB, tb) != 15; i++) cycle(1'b0, 1, 1'b0);
    cycle(1'b1, 0, 1'b0);

    // Directed underflow sequence at (5,1)/(6,1) of the larger mode.
    repeat (36) cycle(1'b0, 1, 1'b0);
    cycle(1'b0, 1, 1'b1);
    cycle(1'b0, 2, 1'b1);
    cycle(1'b0, 2, 1'b0);
    cycle(1'b0, 1, 1'b0);
    cycle(1'b0, 1, 1'b1);
    cycle(1'b0, 1, 1'b0);

    // Long random run with all-valid stretches to exercise clean frames.
    repeat (450) cycle(1'b0, 1, ($urandom_range(0, 15) == 0));
    repeat (450) cycle(1'b0, 0, ($urandom_range(0, 5) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
